// File: rtl/restoring_div_param.sv
// +--------------------------------------------------------------------------+
// | restoring_div_param : multi-cycle restoring divider, signed/unsigned     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module restoring_div_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] inbus1,
  input  logic [WIDTH-1:0] inbus2,
  output logic [WIDTH-1:0] cat,
  output logic [WIDTH-1:0] rest,
  output logic             done,
  output logic             busy,
  output logic             dbz,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] dividend_raw;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             zero_div;
  logic             ovf_case;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             step_neg;

  // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    mag1     = (sgn && inbus1[WIDTH-1]) ? (~inbus1 + 1'b1) : inbus1;
    mag2     = (sgn && inbus2[WIDTH-1]) ? (~inbus2 + 1'b1) : inbus2;
    shifted  = {acc, quo[WIDTH-1]};
    diff     = shifted - {1'b0, div_mag};
    step_neg = diff[WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (inbus2 == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_STEP) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cat          <= '0;
      rest         <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      dbz          <= 1'b0;
      ovf          <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      quo          <= '0;
      div_mag      <= '0;
      dividend_raw <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      zero_div     <= 1'b0;
      ovf_case     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc          <= '0;
            quo          <= mag1;
            div_mag      <= mag2;
            dividend_raw <= inbus1;
            sign_q       <= sgn & (inbus1[WIDTH-1] ^ inbus2[WIDTH-1]);
            sign_r       <= sgn & inbus1[WIDTH-1];
            zero_div     <= (inbus2 == '0);
            ovf_case     <= sgn && (inbus1 == MIN_NEG) && (inbus2 == '1);
            busy         <= 1'b1;
            cnt          <= '0;
            dbz          <= 1'b0;
            ovf          <= 1'b0;
          end
        end
        RUN: begin
          // A negative trial difference means the divisor did not fit: keep the shifted value.
          acc <= step_neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~step_neg};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (zero_div) begin
            cat  <= '1;
            rest <= dividend_raw;
            dbz  <= 1'b1;
            ovf  <= 1'b0;
          end else if (ovf_case) begin
            cat  <= MIN_NEG;
            rest <= '0;
            dbz  <= 1'b0;
            ovf  <= 1'b1;
          end else begin
            cat  <= sign_q ? (~quo + 1'b1) : quo;
            rest <= sign_r ? (~acc + 1'b1) : acc;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/restoring_div_param.md
Name: restoring_div_param

Overview:
- Parametrised, sequential restoring divider with built-in sign handling.
- Replaces the external sign-split stage plus the fixed 8-bit unsigned divider core.
- Supports signed and unsigned modes per operation, with divide-by-zero and overflow flags and a start/busy/done handshake.
- Sits in the arithmetic datapath as a standalone multi-cycle unit.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only when busy=0
sgn  input  1  1 = operands two's-complement signed, 0 = unsigned; sampled with start
inbus1  input  WIDTH  dividend, sampled on accepting edge
inbus2  input  WIDTH  divisor, sampled on accepting edge
cat  output  WIDTH  quotient, registered
rest  output  WIDTH  remainder, registered
done  output  1  one-cycle pulse, results valid
busy  output  1  operation in progress
dbz  output  1  divide-by-zero flag, valid with done
ovf  output  1  signed overflow flag, valid with done

Behaviour:
- Reset: clk edge with rst=1 forces state IDLE and clears cat, rest, done, busy, dbz, ovf and the counter.
- Reset mid-operation aborts the operation; no done is issued.
- States: IDLE, RUN, FIX.
- IDLE, start=1 (edge E0):
  - Latch sgn and operand magnitudes. In signed mode, magnitude = two's-complement negate when MSB=1, held as WIDTH-bit unsigned, so -2^(WIDTH-1) gives 2^(WIDTH-1).
  - Latch sign_q = s1^s2 and sign_r = s1 (both 0 when sgn=0).
  - Set busy=1, clear counter, clear dbz/ovf.
  - Divisor==0: go to FIX directly.
  - Otherwise: go to RUN.
- RUN: one restoring step per edge, on edges E1..EWIDTH.
  - Shift {A,Q} left 1.
  - A' = A - M, computed at WIDTH+1 bits.
  - If A' is negative: restore A and set Q[0]=0. Else: A=A' and Q[0]=1.
  - Increment counter. After the WIDTH-th step, go to FIX.
- FIX (one edge; EWIDTH+1 normally, E1 for divide-by-zero):
  - Normal: cat = sign_q ? -Q : Q; rest = sign_r ? -A : A.
  - Divide-by-zero: cat = all ones, rest = inbus1 as latched (raw), dbz=1, ovf=0.
  - Signed overflow (sgn=1, dividend = -2^(WIDTH-1), divisor = -1): cat = -2^(WIDTH-1), rest = 0, ovf=1.
  - Always: done=1, busy=0, go to IDLE.
- Latency: done asserted in the cycle after edge EWIDTH+1 (WIDTH+1 edges after acceptance); 1 edge after acceptance for divide-by-zero.
- done lasts exactly one cycle.
- cat, rest, dbz and ovf hold until the next FIX or reset.
- Division semantics: truncation toward zero; remainder takes the dividend's sign; |rest| < |divisor|; dividend = cat*divisor + rest (mod 2^WIDTH when not overflowing).
- start while busy=1 is ignored, with no effect on the operation in flight.
- Back-to-back: start high in the done cycle is accepted, since state is already IDLE. That edge clears done and sets busy.
- sgn, inbus1 and inbus2 may change freely after the accepting edge.

Test Plan:
1. WIDTH=8, sgn=1:
   - -49/-3 -> cat=16, rest=-1, dbz=0, ovf=0.
   - 49/-3 -> cat=-16, rest=1.
   - 59/4 -> cat=14, rest=3.
   - Check done rises exactly 9 edges after acceptance and lasts 1 cycle.
2. Unsigned, sgn=0: 200/7 (0xC8/0x07) -> cat=28, rest=4. The same bits with sgn=1 (-56/7) -> cat=-8, rest=0.
3. Divide-by-zero: 37/0, sgn=1 -> done 1 edge after acceptance, dbz=1, cat=0xFF, rest=37.
4. Overflow and boundaries, sgn=1:
   - -128/-1 -> ovf=1, cat=-128, rest=0.
   - -128/1 -> cat=-128, rest=0, ovf=0.
   - 5/9 -> cat=0, rest=5.
5. Handshake:
   - Pulse start with 100/3 during busy of 59/4 -> ignored; result is 14/3.
   - Start 100/3 in the done cycle -> accepted; cat=33, rest=1 nine edges later.
6. Reset and WIDTH=16:
   - Assert rst at edge E4 of an operation -> all outputs 0, no done.
   - Then 1000/-7 -> cat=-142, rest=6.
   - With WIDTH=16: -30000/123 -> cat=-243, rest=-111, done 17 edges after acceptance.
